// File: rtl/mult_div_seq.sv
// mult_div_seq -- sequential signed 32x32 multiply / divide unit.
//
// A multiply produces the full 64-bit signed product in {hi_out, lo_out}.
// A divide produces the quotient in lo_out and the remainder in hi_out,
// truncating toward zero (remainder takes the sign of the dividend).
// Both operations work on operand magnitudes: 32 single-bit iterations,
// then one sign-fix cycle that loads the result registers.
//
// Handshake: start_mult / start_div are sampled only while busy is low.
// The edge on which a start is seen is the accepting edge, and it captures
// op_a / op_b. Starts seen while busy are dropped, not queued. Results are
// reported by a one-cycle done pulse; hi_out / lo_out then hold until the
// next result is loaded. A divide by zero skips the iterations, pulses done
// with div_zero one cycle after acceptance and leaves hi_out / lo_out as
// they were.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   start_mult request signed op_a * op_b (wins over start_div)
//   start_div  request signed op_a / op_b
//   op_a       multiplicand / dividend
//   op_b       multiplier / divisor
//   busy       high in every state except IDLE
//   done       one-cycle result strobe
//   div_zero   high with done when the divide had op_b == 0
//   hi_out     product[63:32] or remainder
//   lo_out     product[31:0] or quotient
//   fsm_state  current FSM state (debug observation)
module mult_div_seq #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_mult,
    input  logic              start_div,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              busy,
    output logic              done,
    output logic              div_zero,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out,
    output logic [2:0]        fsm_state
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] MULT = 3'd1;
    localparam logic [2:0] DIV  = 3'd2;
    localparam logic [2:0] FIX  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]          state;
    logic [4:0]          count;
    logic                is_div;
    logic                dz_flag;
    logic                sign_q;      // product / quotient sign
    logic                sign_r;      // remainder sign
    // operand: multiplicand magnitude (MULT) or divisor magnitude (DIV).
    logic [DATA_W-1:0]   operand;
    // acc: MULT -> {partial product high, remaining multiplier bits}
    //      DIV  -> {partial remainder, dividend bits becoming quotient}
    logic [2*DATA_W-1:0] acc;

    logic [DATA_W-1:0]   abs_a;
    logic [DATA_W-1:0]   abs_b;
    logic [DATA_W:0]     add_sum;
    logic [DATA_W:0]     div_shift;
    logic [DATA_W:0]     div_diff;
    logic [2*DATA_W-1:0] acc_neg;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;

    // The magnitude of the most negative value is its own bit pattern,
    // which is correct when read as unsigned.
    assign abs_a = op_a[DATA_W-1] ? -op_a : op_a;
    assign abs_b = op_b[DATA_W-1] ? -op_b : op_b;

    // Shift-add: add multiplicand into the high half when the current
    // multiplier bit (acc[0]) is set; the carry becomes the new top bit.
    assign add_sum = {1'b0, acc[2*DATA_W-1:DATA_W]}
                   + (acc[0] ? {1'b0, operand} : {(DATA_W+1){1'b0}});

    // Restoring divide: a borrow out of the 33-bit subtract (bit DATA_W)
    // means the shifted remainder was smaller than the divisor.
    assign div_shift = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
    assign div_diff  = div_shift - {1'b0, operand};

    assign acc_neg = -acc;
    assign quo_fix = sign_q ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
    assign rem_fix = sign_r ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            is_div  <= 1'b0;
            dz_flag <= 1'b0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            operand <= '0;
            acc     <= '0;
            hi_out  <= '0;
            lo_out  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_mult) begin
                        state   <= MULT;
                        count   <= '0;
                        is_div  <= 1'b0;
                        dz_flag <= 1'b0;
                        sign_q  <= op_a[DATA_W-1] ^ op_b[DATA_W-1];
                        sign_r  <= op_a[DATA_W-1];
                        operand <= abs_a;
                        acc     <= {{DATA_W{1'b0}}, abs_b};
                    end else if (start_div) begin
                        is_div <= 1'b1;
                        if (op_b == '0) begin
                            state   <= DONE;
                            dz_flag <= 1'b1;
                        end else begin
                            state   <= DIV;
                            count   <= '0;
                            dz_flag <= 1'b0;
                            sign_q  <= op_a[DATA_W-1] ^ op_b[DATA_W-1];
                            sign_r  <= op_a[DATA_W-1];
                            operand <= abs_b;
                            acc     <= {{DATA_W{1'b0}}, abs_a};
                        end
                    end
                end
                MULT: begin
                    acc   <= {add_sum, acc[DATA_W-1:1]};
                    count <= count + 5'd1;
                    if (count == 5'd31) state <= FIX;
                end
                DIV: begin
                    if (div_diff[DATA_W])
                        acc <= {div_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
                    else
                        acc <= {div_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
                    count <= count + 5'd1;
                    if (count == 5'd31) state <= FIX;
                end
                FIX: begin
                    if (is_div) begin
                        hi_out <= rem_fix;
                        lo_out <= quo_fix;
                    end else begin
                        hi_out <= sign_q ? acc_neg[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
                        lo_out <= sign_q ? acc_neg[DATA_W-1:0] : acc[DATA_W-1:0];
                    end
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign div_zero  = done & dz_flag;
    assign fsm_state = state;

endmodule

// File: tb/tb_mult_div_seq.sv
// Testbench for mult_div_seq: drives multiply/divide requests, pushes the
// expected {div_zero, hi, lo} onto a queue at acceptance and pops it when
// done is seen. Timing (latency, busy length, accept spacing) and reset
// behaviour are checked inline in each scenario task.
module tb_mult_div_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_mult;
    logic        start_div;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic [2:0]  fsm_state;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    logic [64:0] exp_q[$];
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    mult_div_seq #(.DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero),
        .hi_out     (hi_out),
        .lo_out     (lo_out),
        .fsm_state  (fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    // Returns {div_zero, hi, lo} for an accepted operation and tracks the
    // Hi/Lo contents so a divide by zero can expect them unchanged.
    function automatic logic [64:0] model(input logic is_div, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        logic [31:0] q;
        logic [31:0] r;
        if (!is_div) begin
            p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            model_hi = p[63:32];
            model_lo = p[31:0];
        end else if (b == 32'h0) begin
            return {1'b1, model_hi, model_lo};
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            model_hi = 32'h0;
            model_lo = 32'h8000_0000;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            model_hi = r;
            model_lo = q;
        end
        return {1'b0, model_hi, model_lo};
    endfunction

    // ---------------- driver ----------------
    // Issues one request from IDLE, waits (bounded) for done and reports
    // latency in cycles after the accepting edge, busy cycles, the result
    // seen with done, and busy one cycle after done.
    task automatic run_op(input logic sm, input logic sd, input logic [31:0] a, input logic [31:0] b,
                          input bit disturb, output int lat, output int busy_cnt,
                          output logic [64:0] got, output logic busy_after);
        @(negedge clk);
        start_mult = sm;
        start_div  = sd;
        op_a       = a;
        op_b       = b;
        exp_q.push_back(model(!sm, a, b));
        lat      = 0;
        busy_cnt = 0;
        do begin
            @(negedge clk);
            lat++;
            start_mult = 1'b0;
            start_div  = 1'b0;
            if (busy) busy_cnt++;
            if (disturb) begin
                op_a = $urandom;
                op_b = $urandom;
                if (lat == 5) start_div = 1'b1;
                if (lat == 9) start_mult = 1'b1;
            end
        end while (!done && lat < 60);
        got        = {div_zero, hi_out, lo_out};
        start_mult = 1'b0;
        start_div  = 1'b0;
        @(negedge clk);
        busy_after = busy;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        reset      = 1'b1;
        start_mult = 1'b1;
        start_div  = 1'b1;
        op_a       = 32'd5;
        op_b       = 32'd0;
        repeat (3) @(negedge clk);
        compared++;
        if ({busy, done, div_zero} !== 3'b000) begin
            mismatched++;
            $display("FAIL reset_flags got %b exp 000", {busy, done, div_zero});
        end
        compared++;
        if ({hi_out, lo_out} !== 64'h0) begin
            mismatched++;
            $display("FAIL reset_hilo got %h exp 0", {hi_out, lo_out});
        end
        compared++;
        if (fsm_state !== 3'd0) begin
            mismatched++;
            $display("FAIL reset_state got %0d exp 0", fsm_state);
        end
        reset      = 1'b0;
        start_mult = 1'b0;
        start_div  = 1'b0;
        @(negedge clk);
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_start_ignored busy got %b exp 0", busy);
        end
    endtask

    task automatic test_mult;
        int lat, bc; logic [64:0] got, exp; logic ba;
        run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0, lat, bc, got, ba);
        exp = exp_q.pop_front();
        compared++;
        if (got !== exp) begin mismatched++; $display("FAIL mult_result got %h exp %h", got, exp); end
        compared++;
        if (got !== {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB}) begin
            mismatched++; $display("FAIL mult_const got %h exp 0ffffffffffffffeb", got);
        end
        compared++;
        if (lat != 34) begin mismatched++; $display("FAIL mult_latency got %0d exp 34", lat); end
        compared++;
        if (bc != 34 || ba !== 1'b0) begin
            mismatched++; $display("FAIL mult_busy got %0d/%b exp 34/0", bc, ba);
        end
    endtask

    task automatic test_div;
        int lat, bc; logic [64:0] got, exp; logic ba;
        run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, bc, got, ba);
        exp = exp_q.pop_front();
        compared++;
        if (got !== exp || got !== {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
            mismatched++; $display("FAIL div_result got %h exp %h", got, exp);
        end
        compared++;
        if (lat != 34) begin mismatched++; $display("FAIL div_latency got %0d exp 34", lat); end
    endtask

    task automatic test_div_zero;
        int lat, bc; logic [64:0] got, exp; logic ba;
        run_op(1'b1, 1'b0, 32'h0000_1234, 32'hFFFF_5678, 1'b0, lat, bc, got, ba);
        exp = exp_q.pop_front();
        compared++;
        if (got !== exp) begin mismatched++; $display("FAIL preload_result got %h exp %h", got, exp); end
        run_op(1'b0, 1'b1, 32'd5, 32'd0, 1'b0, lat, bc, got, ba);
        exp = exp_q.pop_front();
        compared++;
        if (got !== exp) begin mismatched++; $display("FAIL divzero_result got %h exp %h", got, exp); end
        compared++;
        if (lat != 1 || bc != 1 || ba !== 1'b0) begin
            mismatched++; $display("FAIL divzero_timing got %0d/%0d/%b exp 1/1/0", lat, bc, ba);
        end
        compared++;
        if (div_zero !== 1'b0 || {hi_out, lo_out} !== {model_hi, model_lo}) begin
            mismatched++; $display("FAIL divzero_after got %b %h exp 0 %h", div_zero, {hi_out, lo_out}, {model_hi, model_lo});
        end
    endtask

    task automatic test_both_starts;
        int lat, bc; logic [64:0] got, exp; logic ba;
        run_op(1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1, lat, bc, got, ba);
        exp = exp_q.pop_front();
        compared++;
        if (got !== exp || got !== {1'b0, 32'h4000_0000, 32'h0}) begin
            mismatched++; $display("FAIL both_result got %h exp %h", got, exp);
        end
        compared++;
        if (lat != 34 || ba !== 1'b0) begin
            mismatched++; $display("FAIL both_timing got %0d/%b exp 34/0", lat, ba);
        end
    endtask

    task automatic test_reset_mid;
        int lat, bc, dcount; logic [64:0] got, exp; logic ba;
        @(negedge clk);
        start_mult = 1'b1;
        op_a       = 32'h0001_2345;
        op_b       = 32'h0000_0F0F;
        @(negedge clk);
        start_mult = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        compared++;
        if ({busy, done, hi_out, lo_out} !== 66'h0) begin
            mismatched++; $display("FAIL reset_mid got %b%b %h exp 00 0", busy, done, {hi_out, lo_out});
        end
        reset    = 1'b0;
        model_hi = '0;
        model_lo = '0;
        dcount   = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcount++;
        end
        compared++;
        if (dcount != 0) begin mismatched++; $display("FAIL reset_mid_no_done got %0d exp 0", dcount); end
        run_op(1'b0, 1'b1, 32'd100, 32'd7, 1'b0, lat, bc, got, ba);
        exp = exp_q.pop_front();
        compared++;
        if (got !== exp || got !== {1'b0, 32'd2, 32'd14}) begin
            mismatched++; $display("FAIL after_reset_div got %h exp %h", got, exp);
        end
    endtask

    task automatic test_random;
        int lat, bc, exp_lat; logic [64:0] got, exp; logic ba, sel; logic [31:0] a, b;
        for (int i = 0; i < 12; i++) begin
            sel = 1'($urandom_range(0, 1));
            a   = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'($urandom_range(0, 9));
                1:       b = -32'($urandom_range(1, 9));
                default: b = $urandom;
            endcase
            if (i == 0) begin sel = 1'b1; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            run_op(1'b0 == sel, sel, a, b, 1'b0, lat, bc, got, ba);
            exp     = exp_q.pop_front();
            exp_lat = (sel && b == 32'h0) ? 1 : 34;
            compared++;
            if (got !== exp) begin
                mismatched++; $display("FAIL rand_result[%0d] a=%h b=%h div=%b got %h exp %h", i, a, b, sel, got, exp);
            end
            compared++;
            if (lat != exp_lat) begin
                mismatched++; $display("FAIL rand_latency[%0d] got %0d exp %0d", i, lat, exp_lat);
            end
        end
    endtask

    task automatic test_back_to_back;
        int t_acc[4]; int w; logic [31:0] a, b; logic [64:0] got, exp;
        @(negedge clk);
        a = $urandom; b = $urandom;
        op_a = a; op_b = b; start_mult = 1'b1;
        exp_q.push_back(model(1'b0, a, b));
        for (int k = 0; k < 4; k++) begin
            w = 0;
            while (!busy && w < 50) begin @(negedge clk); w++; end
            t_acc[k] = cyc;
            if (k < 3) begin
                a = $urandom; b = $urandom;
                op_a = a; op_b = b;
                exp_q.push_back(model(1'b0, a, b));
            end else begin
                start_mult = 1'b0;
            end
            w = 0;
            while (!done && w < 50) begin @(negedge clk); w++; end
            got = {div_zero, hi_out, lo_out};
            exp = exp_q.pop_front();
            compared++;
            if (got !== exp) begin mismatched++; $display("FAIL b2b_result[%0d] got %h exp %h", k, got, exp); end
            if (k > 0) begin
                compared++;
                if (t_acc[k] - t_acc[k-1] != 35) begin
                    mismatched++; $display("FAIL b2b_spacing[%0d] got %0d exp 35", k, t_acc[k] - t_acc[k-1]);
                end
            end
            w = 0;
            while (busy && w < 50) begin @(negedge clk); w++; end
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        reset      = 1'b1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        op_a       = '0;
        op_b       = '0;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_both_starts();
        test_reset_mid();
        test_random();
        test_back_to_back();
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++; $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mult_div_seq.md
MULT_DIV_SEQ -- requirements
Module: mult_div_seq

Interface
REQ-001 Parameter: DATA_W, default 32, operand and Hi/Lo width; only 32 is supported.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 start_mult  input  1  request signed multiply of op_a*op_b; sampled only in IDLE.
REQ-005 start_div  input  1  request signed divide op_a/op_b; sampled only in IDLE.
REQ-006 op_a  input  32  multiplicand / dividend, captured on the accepting edge.
REQ-007 op_b  input  32  multiplier / divisor, captured on the accepting edge.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  high for exactly one cycle, while in DONE.
REQ-010 div_zero  output  1  high with done when the accepted divide had op_b==0; low otherwise.
REQ-011 hi_out  output  32  Hi register: product[63:32] or remainder.
REQ-012 lo_out  output  32  Lo register: product[31:0] or quotient.

Function
REQ-013 The FSM SHALL have states IDLE, MULT, DIV, FIX and DONE, plus a 5-bit iteration counter.
REQ-014 In IDLE with start_mult=1, the block SHALL capture the operands and enter MULT with counter=0.
REQ-015 If start_mult and start_div are both high, multiply SHALL win and the divide request SHALL be dropped.
REQ-016 In IDLE with start_div=1 and op_b!=0, the block SHALL capture the operands and enter DIV with counter=0.
REQ-017 In IDLE with start_div=1 and op_b==0, the block SHALL go directly to DONE with div_zero=1 and SHALL leave hi_out/lo_out unchanged.
REQ-018 On capture, operands SHALL be converted to magnitudes and the result signs recorded:
- product sign = sign(a) XOR sign(b)
- quotient sign = sign(a) XOR sign(b)
- remainder sign = sign(a)
REQ-019 MULT SHALL perform one unsigned shift-add step per cycle; DIV SHALL perform one restoring shift-subtract step per cycle.
REQ-020 After the step at counter==31 (32 steps total), MULT or DIV SHALL enter FIX.
REQ-021 FIX SHALL, in one cycle, apply two's-complement sign correction to the results and load hi_out/lo_out, then enter DONE.
REQ-022 Timing: with acceptance at edge E0, hi_out/lo_out SHALL be valid and done=1 after edge E33.
REQ-023 From DONE the FSM SHALL return to IDLE on the next edge; a start can be accepted at the earliest on the edge after that.
REQ-024 Start requests while busy=1 SHALL be ignored and SHALL not be queued.
REQ-025 hi_out/lo_out SHALL change only on the FIX->DONE transition or on reset; they SHALL hold between operations.
REQ-026 Multiply SHALL produce the full signed 64-bit product; no overflow flag.
REQ-027 Divide SHALL truncate toward zero.
REQ-028 Divide of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000.
REQ-029 Operand inputs SHALL be ignored after capture; changing them mid-operation SHALL not affect the result.

Reset
REQ-030 While reset=1 at a rising edge:
- state=IDLE, counter=0
- busy=0, done=0, div_zero=0
- hi_out=0, lo_out=0
- internal operand and partial registers cleared
REQ-031 Reset mid-operation SHALL abort the operation with no done pulse; the first start after reset deasserts SHALL execute normally.
REQ-032 start_mult/start_div high in the same cycle as reset SHALL be ignored.

Verification
REQ-033 Multiply 7 * 0xFFFFFFFD (-3) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; done after E33; busy high for 34 cycles.
REQ-034 Divide 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); div_zero=0.
REQ-035 With Hi/Lo preloaded from a prior op, divide 5 / 0 -> done and div_zero high one cycle after acceptance; hi/lo unchanged.
REQ-036 start_mult and start_div together with a=0x80000000, b=0x80000000 -> multiply executes: hi=0x40000000, lo=0; a start pulsed during busy is ignored.
REQ-037 Reset asserted at iteration 10 of a multiply -> busy=0, hi=lo=0, no done; then 100/7 -> lo=14, hi=2.
REQ-038 Back-to-back ops: a start held high continuously -> one accept per 35 cycles, each with correct results.
